// File: rtl/data_mem_if.sv
// Request/response bus between the MEM stage and the data memory.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// The requester holds req_we/req_sel/req_addr/req_wdata stable while req_valid
// is high and req_ready is low. The memory captures the fields on the accepting
// edge; they are don't-care afterwards. rsp_valid is a one-cycle pulse, and
// rsp_err/rsp_rdata are meaningful only while it is high.
//
// Signals:
//   req_valid, req_ready            request handshake
//   req_we                          1 = store, 0 = load
//   req_sel[2:0]                    funct3 width/sign select
//   req_addr[31:0], req_wdata[31:0] byte address, LSB-aligned store data
//   rsp_valid, rsp_rdata[31:0], rsp_err  response pulse, load data, reject flag
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_sel;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_sel, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_sel, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressed synchronous data memory for the RISC-V load/store path.
// Four byte lanes of DEPTH_WORDS x 8. Accesses crossing a word boundary are
// split into two word accesses (word N on the accepting edge, word N+1 on the
// next edge). Illegal selects, stores with an unsigned select, out-of-range
// accesses and (when ALLOW_MISALIGNED=0) misaligned accesses are rejected.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        data_mem_if slave side (request/response)
//   dbg_state  current FSM state (IDLE=0, ACC1=1, ACC2=2, RESP=3)
module data_mem_ctrl #(
  parameter int DEPTH_WORDS      = 64,
  parameter int ADDRW            = $clog2(DEPTH_WORDS * 4),
  parameter     INIT_F           = "",
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int          IDXW      = ADDRW - 2;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;
  state_t state, state_nx;

  logic [7:0] mem [4][DEPTH_WORDS];

  // Request decode (combinational from the bus, used on the accepting edge)
  logic [1:0]      lane;
  logic [IDXW-1:0] idx;
  logic [2:0]      size_m1;
  logic [3:0]      be_base;
  logic            sel_ok, misaligned, req_err, req_split;
  logic [32:0]     last_byte;
  logic [63:0]     wide_data;
  logic [7:0]      wide_be;
  logic            accept;

  assign lane = bus.req_addr[1:0];
  assign idx  = bus.req_addr[ADDRW-1:2];

  always_comb begin
    size_m1 = 3'd0;
    be_base = 4'b0001;
    sel_ok  = 1'b1;
    case (bus.req_sel)
      3'b000, 3'b100: begin size_m1 = 3'd0; be_base = 4'b0001; end
      3'b001, 3'b101: begin size_m1 = 3'd1; be_base = 4'b0011; end
      3'b010:         begin size_m1 = 3'd3; be_base = 4'b1111; end
      default:        sel_ok = 1'b0;
    endcase
    // 33-bit sum so set upper address bits can never wrap into range
    last_byte  = {1'b0, bus.req_addr} + {30'd0, size_m1};
    // size_m1 doubles as the alignment mask: H needs lane[0]=0, W needs lane=0
    misaligned = (lane & size_m1[1:0]) != 2'b00;
    req_err    = !sel_ok || (bus.req_we && bus.req_sel[2]) ||
                 (last_byte >= MEM_BYTES) || (!ALLOW_MISALIGNED && misaligned);
    req_split  = !req_err && (({1'b0, lane} + size_m1) > 3'd3);
  end

  // 8-byte window spanning words N and N+1; low half -> N, high half -> N+1
  assign wide_data = {32'd0, bus.req_wdata} << {lane, 3'b000};
  assign wide_be   = {4'd0, be_base} << lane;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // Captured request
  logic            we_q, err_q, split_q;
  logic [2:0]      sel_q;
  logic [1:0]      lane_q;
  logic [IDXW-1:0] idx_q, idx_hi;
  logic [31:0]     hi_data_q;
  logic [3:0]      hi_be_q;

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q      <= bus.req_we;
      err_q     <= req_err;
      split_q   <= req_split;
      sel_q     <= bus.req_sel;
      lane_q    <= lane;
      idx_q     <= idx;
      hi_data_q <= wide_data[63:32];
      hi_be_q   <= wide_be[7:4];
    end
  end

  assign idx_hi = idx_q + 1'b1;

  // Memory: first word on accept, second word in ACC1 for split accesses.
  // The second-half write is suppressed by reset so an interrupted split
  // store never reaches word N+1.
  logic        wr_lo, wr_hi, rd_hi_en;
  logic [31:0] rd_lo, rd_hi;

  assign wr_lo    = accept && bus.req_we && !req_err;
  assign rd_hi_en = (state == ACC1) && split_q;
  assign wr_hi    = rd_hi_en && we_q && !rst;

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_lo && wide_be[l]) mem[l][idx] <= wide_data[8*l +: 8];
      if (wr_hi && hi_be_q[l]) mem[l][idx_hi] <= hi_data_q[8*l +: 8];
      if (accept)   rd_lo[8*l +: 8] <= mem[l][idx];
      if (rd_hi_en) rd_hi[8*l +: 8] <= mem[l][idx_hi];
    end
  end

  // Load formatting: shift the two-word window down to the addressed byte
  logic [31:0] win, load_data;
  assign win = 32'({rd_hi, rd_lo} >> {lane_q, 3'b000});

  always_comb begin
    load_data = win;
    case (sel_q)
      3'b000:  load_data = {{24{win[7]}}, win[7:0]};
      3'b001:  load_data = {{16{win[15]}}, win[15:0]};
      3'b100:  load_data = {24'd0, win[7:0]};
      3'b101:  load_data = {16'd0, win[15:0]};
      default: load_data = win;
    endcase
  end

  // FSM
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = ACC1;
      ACC1:    state_nx = split_q ? ACC2 : RESP;
      ACC2:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  logic        rsp_valid_q, rsp_err_q;
  logic [31:0] rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'd0;
    end else begin
      state       <= state_nx;
      rsp_valid_q <= (state_nx == RESP);
      rsp_err_q   <= (state_nx == RESP) && err_q;
      rsp_rdata_q <= ((state_nx == RESP) && !err_q && !we_q) ? load_data : 32'd0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign dbg_state     = state;
endmodule

// File: tb/tb_data_mem_ctrl.sv
`timescale 1ns/1ps
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_if b0();
  data_mem_if b1();
  logic [1:0] st0, st1;

  // dut0 splits word-crossing accesses, dut1 rejects misaligned ones
  data_mem_ctrl #(.DEPTH_WORDS(64), .ALLOW_MISALIGNED(1'b1)) dut0 (
    .clk(clk), .rst(rst), .bus(b0), .dbg_state(st0));
  data_mem_ctrl #(.DEPTH_WORDS(64), .ALLOW_MISALIGNED(1'b0)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .dbg_state(st1));

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  int          prev_lat = 0;
  logic        prev_v [2];
  logic [7:0]  ref_mem [2][256];
  logic [34:0] exp_q0[$];
  logic [34:0] exp_q1[$];
  longint      acc_q0[$];
  longint      acc_q1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte array, RISC-V width/sign rules, range/align errors.
  // Latency is counted in cycles from the accept cycle to the response cycle.
  function automatic void model(input int w, input logic we, input logic [2:0] sel,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic er, output int lat);
    int size;
    longint last;
    logic [31:0] v;
    case (sel)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    er = (size == 0) || (we && sel[2]);
    last = longint'(addr) + size - 1;
    if (last >= 256) er = 1'b1;
    if (size != 0 && w == 1 && (addr % size) != 0) er = 1'b1;
    lat = (!er && ((addr % 4) + size > 4)) ? 3 : 2;
    rd = 32'd0;
    v  = 32'd0;
    if (!er) begin
      for (int i = 0; i < size; i++) begin
        if (we) ref_mem[w][int'(addr) + i] = wdata[8*i +: 8];
        else    v[8*i +: 8] = ref_mem[w][int'(addr) + i];
      end
      if (!we) begin
        case (sel)
          3'b000:  rd = {{24{v[7]}}, v[7:0]};
          3'b001:  rd = {{16{v[15]}}, v[15:0]};
          default: rd = v;
        endcase
      end
    end
  endfunction

  task automatic drive(input int w, input logic v, input logic we, input logic [2:0] sel,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (w == 0) begin
      b0.req_valid = v; b0.req_we = we; b0.req_sel = sel;
      b0.req_addr = addr; b0.req_wdata = wdata;
    end else begin
      b1.req_valid = v; b1.req_we = we; b1.req_sel = sel;
      b1.req_addr = addr; b1.req_wdata = wdata;
    end
  endtask

  // keep: leave req_valid high afterwards (back-to-back); gap_chk: the cycles
  // spent waiting for ready must equal the previous request's busy time.
  task automatic send(input int w, input logic we, input logic [2:0] sel,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input bit keep = 0, input bit gap_chk = 0);
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    @(negedge clk);
    drive(w, 1'b1, we, sel, addr, wdata);
    n = 0;
    while (!(w == 1 ? b1.req_ready : b0.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("ready_timeout", n, 0);
      drive(w, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
      return;
    end
    if (gap_chk) check("ready_low_cycles", n, prev_lat);
    model(w, we, sel, addr, wdata, rd, er, lat);
    if (w == 0) begin exp_q0.push_back({lat[1:0], er, rd}); acc_q0.push_back(cyc); end
    else        begin exp_q1.push_back({lat[1:0], er, rd}); acc_q1.push_back(cyc); end
    prev_lat = lat;
    @(posedge clk);
    #1;
    if (!keep) drive(w, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
  endtask

  task automatic mon(input int w, input logic v, input logic [31:0] rd, input logic er);
    logic [34:0] e;
    longint      a;
    if (v) begin
      if (prev_v[w]) check("rsp_pulse_len", prev_v[w], 0);
      if ((w == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
        check("rsp_unexpected", v, 0);
      end else begin
        if (w == 0) begin e = exp_q0.pop_front(); a = acc_q0.pop_front(); end
        else        begin e = exp_q1.pop_front(); a = acc_q1.pop_front(); end
        check(w == 0 ? "rsp_rdata0" : "rsp_rdata1", rd, e[31:0]);
        check(w == 0 ? "rsp_err0" : "rsp_err1", er, e[32]);
        check("rsp_latency", cyc - a, e[34:33]);
      end
    end
    prev_v[w] = v;
  endtask

  always @(negedge clk) begin
    mon(0, b0.rsp_valid, b0.rsp_rdata, b0.rsp_err);
    mon(1, b1.rsp_valid, b1.rsp_rdata, b1.rsp_err);
  end

  task automatic drain();
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
  endtask

  initial begin
    logic [2:0] rsel [7] = '{LB, LH, LW, LBU, LHU, 3'b011, 3'b110};
    logic [31:0] a;
    int n;
    prev_v[0] = 1'b0;
    prev_v[1] = 1'b0;
    drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready0", b0.req_ready, 0);
    check("rst_ready1", b1.req_ready, 0);
    check("rst_valid", b0.rsp_valid, 0);
    check("rst_err", b0.rsp_err, 0);
    check("rst_rdata", b0.rsp_rdata, 0);
    check("rst_state", st0, 0);
    rst = 1'b0;
    #1 check("ready_after_rst", b0.req_ready, 1);

    // Fill both memories so every in-range load has a known expectation
    for (int i = 0; i < 64; i++) send(0, 1'b1, LW, i * 4, $urandom);
    for (int i = 0; i < 4; i++)  send(1, 1'b1, LW, i * 4, $urandom);

    // Aligned word and sub-word loads
    send(0, 1'b1, LW, 32'h10, 32'hDEADBEEF);
    send(0, 1'b0, LW, 32'h10, 0);   // DEADBEEF, latency 2
    send(0, 1'b0, LB, 32'h10, 0);   // FFFFFFEF
    send(0, 1'b0, LBU, 32'h10, 0);  // 000000EF
    send(0, 1'b0, LH, 32'h12, 0);   // FFFFDEAD
    send(0, 1'b0, LHU, 32'h12, 0);  // 0000DEAD

    // Split accesses
    send(0, 1'b1, LW, 32'h0D, 32'h11223344);
    for (int i = 12; i <= 17; i++) send(0, 1'b0, LBU, i, 0); // 0x0C kept, 44 33 22 11, 0x11 kept
    send(0, 1'b0, LW, 32'h0D, 0);   // 11223344, latency 3
    send(0, 1'b0, LH, 32'h0F, 0);   // 0x1122 from two words
    send(0, 1'b1, LH, 32'h27, 32'h0000C0DE);
    send(0, 1'b0, LW, 32'h24, 0);
    send(0, 1'b0, LW, 32'h28, 0);

    // Errors and top-of-memory boundaries
    send(0, 1'b0, LW, 32'hFE, 0);
    send(0, 1'b1, LBU, 32'h20, 32'h000000AA);
    send(0, 1'b1, LHU, 32'h20, 32'h0000AAAA);
    send(0, 1'b0, LW, 32'h20, 0);   // unchanged by the two rejected stores
    send(0, 1'b0, 3'b011, 32'h20, 0);
    send(0, 1'b0, 3'b111, 32'h20, 0);
    send(0, 1'b0, LW, 32'h8000_0010, 0);
    send(0, 1'b0, LW, 32'hFC, 0);
    send(0, 1'b0, LW, 32'hFD, 0);
    send(0, 1'b0, LH, 32'hFF, 0);
    send(0, 1'b1, LB, 32'hFF, 32'h00000080);
    send(0, 1'b0, LB, 32'hFF, 0);
    send(0, 1'b0, LW, 32'h00, 0);   // no wrap onto word 0

    // Misaligned accesses rejected when splitting is disabled
    send(1, 1'b0, LH, 32'h01, 0);
    send(1, 1'b0, LH, 32'h02, 0);
    send(1, 1'b0, LW, 32'h02, 0);
    send(1, 1'b1, LW, 32'h05, 32'h12345678);
    send(1, 1'b0, LW, 32'h04, 0);
    send(1, 1'b0, LB, 32'h03, 0);

    // Back-to-back with req_valid held high
    drain();
    send(0, 1'b0, LW, 32'h10, 0, 1, 0);
    send(0, 1'b0, LW, 32'h0D, 0, 1, 1);
    send(0, 1'b1, LB, 32'h30, 32'h0000007F, 1, 1);
    send(0, 1'b0, LBU, 32'h30, 0, 1, 1);
    send(0, 1'b0, LH, 32'h30, 0, 0, 1);

    // Reset before the second half of a split store commits
    drain();
    @(negedge clk);
    drive(0, 1'b1, 1'b1, LW, 32'h21, 32'hA5A5A5A5);
    n = 0;
    while (!b0.req_ready && n < 20) begin @(negedge clk); n++; end
    check("rst_split_accept", n, 0);
    @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("rst_mid_ready", b0.req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_mid_rst", b0.req_ready, 1);
    repeat (3) @(negedge clk);      // monitor flags any late response
    send(0, 1'b0, LW, 32'h24, 0);   // word N+1 untouched
    send(0, 1'b1, LW, 32'h20, 32'h0BADF00D); // re-establish word N
    send(0, 1'b0, LW, 32'h20, 0);

    // Random mix including illegal selects and out-of-range addresses
    for (int i = 0; i < 80; i++) begin
      a = $urandom_range(0, 259);
      if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
      send(0, 1'($urandom_range(0, 1)), rsel[$urandom_range(0, 6)], a, $urandom);
    end

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
